lstm_gate_seq: RTL and testbench
================================

# lstm_gate_seq

Sequencer that owns the combinational gate quantizer (bias-add / quantize / sigmoid-or-tanh stage) for one LSTM timestep. For each of the four gates (i, f, g, o) and every hidden unit, it accepts the 32-bit inner product from the MAC array and fetches the matching 8-bit bias from bias memory. It then drives the quantizer's mode code and operands, captures the saturated 8-bit result, and hands it downstream over a valid/ready port. It sits between the MAC accumulator, the bias SRAM and the gate-output buffer.

## Interface
- NUM_UNITS, 64, hidden units per gate (≥1)
- UNIT_W, 6, width of the unit index; ≥ clog2(NUM_UNITS), minimum 1
- BIAS_AW, 8, bias address width; must hold 4*NUM_UNITS entries
---
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse that begins a timestep
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last result is accepted downstream
- acc_valid  in  1  inner product available
- acc_ready  out  1  sequencer accepts an inner product
- acc_data  in  32  signed inner product
- bias_rd_en  out  1  bias read strobe
- bias_rd_addr  out  BIAS_AW  bias address, gate*NUM_UNITS+unit
- bias_rd_data  in  8  bias read data; synchronous memory, 1-cycle latency
- comb_ctrl  out  5  quantizer mode code
- inpdt_R_reg  out  32  registered inner product to the quantizer
- bias_buffer  out  8  registered bias to the quantizer
- q_result  in  8  saturated quantizer output
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  8  captured result
- out_gate  out  2  gate of the result: 0=i, 1=f, 2=g, 3=o
- out_unit  out  UNIT_W  unit of the result

## Operation
- FSM states:
  - IDLE → WAIT_ACC on start.
  - WAIT_ACC → FETCH on the acc_valid&acc_ready handshake.
  - FETCH → QUANT unconditionally.
  - QUANT → OUT unconditionally.
  - OUT → WAIT_ACC on out_valid&out_ready when the element is not the last one.
  - OUT → DONE on out_valid&out_ready when the element is the last one.
  - DONE → IDLE unconditionally.
- Traversal order is gate-major: gate 0, units 0..NUM_UNITS-1; then gate 1, and so on; the last element is gate 3, unit NUM_UNITS-1. The unit counter wraps to 0 and increments the gate on the handshake in OUT.
- acc_ready = 1 only in WAIT_ACC.
- On the acc handshake:
  - acc_data is latched into inpdt_R_reg.
  - bias_rd_en pulses for one cycle with bias_rd_addr set.
- FETCH: bias_rd_data is latched into bias_buffer at the end of the cycle.
- QUANT:
  - comb_ctrl = S_BQS (1) for gates 0, 1 and 3; S_BQT (2) for gate 2.
  - q_result is captured into out_data at the end of the cycle, together with out_gate and out_unit.
- comb_ctrl = comb_IDLE (0) in every state except QUANT.
- OUT: out_valid is held, and out_data/out_gate/out_unit are stable, until out_ready.
- start while busy is ignored. acc_valid outside WAIT_ACC is ignored (not consumed).
- The sequencer does no arithmetic on data; it only registers it. Widths pass through unchanged.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. Reset is asynchronous and may occur mid-timestep: the FSM returns to IDLE, and in-flight data and the pending out_valid are dropped without a done pulse.
- busy rises the cycle after start is sampled in IDLE. It falls in the same cycle done pulses: done=1 and busy=0 both occur in the DONE state.
- Per-element latency: acc handshake at cycle t, bias_rd_en at t, comb_ctrl active at t+2, out_valid at t+3.
- Peak throughput: one element every 4 cycles when acc_valid and out_ready are held high. Total is 16*NUM_UNITS+2 cycles from start to done, including the DONE cycle.
- Backpressure: out_ready low stalls the FSM in OUT indefinitely; acc_ready stays low during the stall.
- NUM_UNITS=1: the gate increments on every element, and exactly 4 elements are produced.

## Structure
- Shared package lstm_pkg holds:
  - comb_ctrl codes: comb_IDLE=0, S_BQS=1, S_BQT=2, S_MAQ_BQS=3, S_TMQ=4, B_BQS=5, B_BQT=6, B_MAQ_BQS=7, B_TMQ_BQS=8.
  - Gate indices GATE_I=0, GATE_F=1, GATE_G=2, GATE_O=3.
  - The FSM state encoding.
- One sub-module, gate_unit_cnt, holds the unit/gate counter with wrap and last-element flag. The quantizer itself is instantiated outside this block.

## Test plan
- Reset then idle: all outputs 0, and comb_ctrl=0 for 100 cycles with acc_valid=1 and start=0; no acc handshake occurs.
- NUM_UNITS=4, quantizer attached, acc_data=0, all biases 0, acc_valid and out_ready held high → 16 results of 128; out_gate sequence 0,0,0,0,1,…,3; comb_ctrl=2 only for gate 2; done at cycle 66 after start.
- Bias addressing: for gate 2, unit 3 with NUM_UNITS=4, bias_rd_addr=11 in the same cycle as the acc handshake; bias_buffer equals memory[11] during QUANT.
- Backpressure: out_ready low for 10 cycles on element 5 → out_data/out_gate/out_unit stay stable, acc_ready stays 0, and no result is lost or duplicated.
- Reset asserted with the FSM in QUANT → outputs 0 asynchronously, no done pulse; the next start runs a full 4*NUM_UNITS sequence starting at gate 0, unit 0.
- start pulsed while busy → ignored; exactly one done pulse per accepted start.

Source files
------------

// File: rtl/lstm_gate_seq_pkg.sv
// Shared definitions for the LSTM gate sequencer: quantizer mode codes,
// gate indices and the sequencer state encoding.
package lstm_pkg;

    typedef enum logic [4:0] {
        comb_IDLE = 5'd0,
        S_BQS     = 5'd1,
        S_BQT     = 5'd2,
        S_MAQ_BQS = 5'd3,
        S_TMQ     = 5'd4,
        B_BQS     = 5'd5,
        B_BQT     = 5'd6,
        B_MAQ_BQS = 5'd7,
        B_TMQ_BQS = 5'd8
    } comb_ctrl_e;

    localparam logic [1:0] GATE_I = 2'd0;
    localparam logic [1:0] GATE_F = 2'd1;
    localparam logic [1:0] GATE_G = 2'd2;
    localparam logic [1:0] GATE_O = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ACC,
        ST_FETCH,
        ST_QUANT,
        ST_OUT,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/gate_unit_cnt.sv
// Gate-major element counter: unit 0..NUM_UNITS-1 within each gate, then the
// next gate. Flags the final element (gate o, last unit).
module gate_unit_cnt
    import lstm_pkg::*;
#(
    parameter int NUM_UNITS = 64,
    parameter int UNIT_W    = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_clr,
    input  logic              i_adv,
    output logic [UNIT_W-1:0] o_unit,
    output logic [1:0]        o_gate,
    output logic              o_last
);

    logic [UNIT_W-1:0] r_unit;
    logic [1:0]        r_gate;
    logic              w_unit_wrap;

    assign w_unit_wrap = (r_unit == UNIT_W'(NUM_UNITS - 1));
    assign o_last      = w_unit_wrap && (r_gate == GATE_O);
    assign o_unit      = r_unit;
    assign o_gate      = r_gate;

    // Step the unit, carrying into the gate; after the last element both wrap to 0
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_unit <= '0;
            r_gate <= '0;
        end else if (i_clr) begin
            r_unit <= '0;
            r_gate <= '0;
        end else if (i_adv) begin
            if (w_unit_wrap) begin
                r_unit <= '0;
                r_gate <= r_gate + 2'd1;
            end else begin
                r_unit <= r_unit + UNIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/lstm_gate_seq.sv
// LSTM timestep gate sequencer: pairs each MAC inner product with its bias,
// drives the external quantizer and hands the 8-bit result downstream.
module lstm_gate_seq
    import lstm_pkg::*;
#(
    parameter int NUM_UNITS = 64,
    parameter int UNIT_W    = 6,
    parameter int BIAS_AW   = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic               acc_valid,
    output logic               acc_ready,
    input  logic [31:0]        acc_data,
    output logic               bias_rd_en,
    output logic [BIAS_AW-1:0] bias_rd_addr,
    input  logic [7:0]         bias_rd_data,
    output logic [4:0]         comb_ctrl,
    output logic [31:0]        inpdt_R_reg,
    output logic [7:0]         bias_buffer,
    input  logic [7:0]         q_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic [1:0]         out_gate,
    output logic [UNIT_W-1:0]  out_unit
);

    seq_state_e        r_state;
    seq_state_e        w_next;
    logic              w_acc_hs;
    logic              w_out_hs;
    logic              w_clr;
    logic [UNIT_W-1:0] w_unit;
    logic [1:0]        w_gate;
    logic              w_last;

    assign w_acc_hs     = acc_valid && acc_ready;
    assign w_out_hs     = out_valid && out_ready;
    assign w_clr        = (r_state == ST_IDLE) && start;
    assign bias_rd_addr = BIAS_AW'(w_gate) * BIAS_AW'(NUM_UNITS) + BIAS_AW'(w_unit);

    gate_unit_cnt #(
        .NUM_UNITS (NUM_UNITS),
        .UNIT_W    (UNIT_W)
    ) u_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .i_clr  (w_clr),
        .i_adv  (w_out_hs),
        .o_unit (w_unit),
        .o_gate (w_gate),
        .o_last (w_last)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state selection
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:     if (start)    w_next = ST_WAIT_ACC;
            ST_WAIT_ACC: if (w_acc_hs) w_next = ST_FETCH;
            ST_FETCH:                  w_next = ST_QUANT;
            ST_QUANT:                  w_next = ST_OUT;
            ST_OUT:      if (w_out_hs) w_next = w_last ? ST_DONE : ST_WAIT_ACC;
            ST_DONE:                   w_next = ST_IDLE;
            default:                   w_next = ST_IDLE;
        endcase
    end

    // State-decoded control outputs
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        acc_ready  = 1'b0;
        out_valid  = 1'b0;
        comb_ctrl  = comb_IDLE;
        unique case (r_state)
            ST_WAIT_ACC: begin
                busy      = 1'b1;
                acc_ready = 1'b1;
            end
            ST_FETCH: busy = 1'b1;
            ST_QUANT: begin
                busy      = 1'b1;
                comb_ctrl = (w_gate == GATE_G) ? S_BQT : S_BQS;
            end
            ST_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
        bias_rd_en = acc_valid && acc_ready;
    end

    // Operand and result registers; each loads in exactly one pipeline slot
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inpdt_R_reg <= '0;
            bias_buffer <= '0;
            out_data    <= '0;
            out_gate    <= '0;
            out_unit    <= '0;
        end else begin
            if (w_acc_hs)
                inpdt_R_reg <= acc_data;
            if (r_state == ST_FETCH)
                bias_buffer <= bias_rd_data;
            if (r_state == ST_QUANT) begin
                out_data <= q_result;
                out_gate <= w_gate;
                out_unit <= w_unit;
            end
        end
    end

endmodule

// File: tb/tb_lstm_gate_seq.sv
// Randomized bench for lstm_gate_seq with a bias memory, a behavioural
// quantizer and an element-level reference model.
module tb_lstm_gate_seq;

    localparam int N  = 4;
    localparam int UW = 2;
    localparam int AW = 4;
    localparam int NE = 4 * N;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          acc_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   acc_data = '0;
    logic [7:0]    bias_rd_data = '0;
    logic [7:0]    q_result;
    logic          busy, done, acc_ready, bias_rd_en, out_valid;
    logic [AW-1:0] bias_rd_addr;
    logic [4:0]    comb_ctrl;
    logic [31:0]   inpdt_R_reg;
    logic [7:0]    bias_buffer, out_data;
    logic [1:0]    out_gate;
    logic [UW-1:0] out_unit;

    logic [7:0]    bmem [NE];

    always #5 clk = ~clk;

    lstm_gate_seq #(
        .NUM_UNITS (N),
        .UNIT_W    (UW),
        .BIAS_AW   (AW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .acc_valid    (acc_valid),
        .acc_ready    (acc_ready),
        .acc_data     (acc_data),
        .bias_rd_en   (bias_rd_en),
        .bias_rd_addr (bias_rd_addr),
        .bias_rd_data (bias_rd_data),
        .comb_ctrl    (comb_ctrl),
        .inpdt_R_reg  (inpdt_R_reg),
        .bias_buffer  (bias_buffer),
        .q_result     (q_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_gate     (out_gate),
        .out_unit     (out_unit)
    );

    // Synchronous bias SRAM, one-cycle read latency
    always @(posedge clk) if (bias_rd_en) bias_rd_data <= bmem[bias_rd_addr];

    // Stand-in quantizer: sigmoid-like offset for mode 1, halved slope for mode 2
    function automatic logic [7:0] quant(input logic [4:0] mode, input logic [31:0] a,
                                         input logic [7:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (mode == 5'd0) return 8'd0;
        if (mode == 5'd2) s = s >>> 1;
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return 8'(s + 128);
    endfunction

    assign q_result = quant(comb_ctrl, inpdt_R_reg, bias_buffer);

    function automatic logic [4:0] gate_mode(input int g);
        return (g == 2) ? 5'd2 : 5'd1;
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus knobs
    int p_acc = 100, p_rdy = 100, p_start = 0;
    bit kick = 0, zero_data = 0, bp_mode = 0;
    int bp_cnt = 0;

    // Reference model state
    bit          active = 0, pending = 0;
    int          c = 0, hs_cyc = 0, cons_cyc = 0, elems = 0, cur_k = 0;
    logic [31:0] cur_acc = '0;
    int          n_starts = 0, n_dones = 0, n_aborts = 0, n_res = 0;
    int          start_cyc = 0, done_cyc = 0;

    task automatic drive();
        start     = kick || ($urandom_range(99) < p_start);
        kick      = 0;
        acc_valid = ($urandom_range(99) < p_acc);
        if (zero_data)                    acc_data = '0;
        else if ($urandom_range(3) == 0)  acc_data = $urandom;
        else                              acc_data = 32'($urandom_range(600)) - 32'd300;
        out_ready = ($urandom_range(99) < p_rdy);
        if (bp_mode && elems == 5 && bp_cnt < 10) out_ready = 0;
    endtask

    task automatic sample();
        logic       e_ready, e_valid, e_done, e_busy;
        logic [4:0] e_comb;
        e_ready = active && !pending && (c > cons_cyc) && (elems < NE);
        e_valid = pending && (c >= hs_cyc + 3);
        e_comb  = (pending && c == hs_cyc + 2) ? gate_mode(cur_k / N) : 5'd0;
        e_done  = active && (elems == NE) && (c == cons_cyc + 1);
        e_busy  = active && !e_done;
        check("acc_ready", acc_ready, e_ready);
        check("out_valid", out_valid, e_valid);
        check("comb_ctrl", comb_ctrl, e_comb);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("bias_rd_en", bias_rd_en, e_ready && acc_valid);
        if (done === 1'b1) n_dones++;
        if (pending && c == hs_cyc + 2)
            check("bias_buffer", bias_buffer, bmem[cur_k]);
        if (e_valid) begin
            check("out_data", out_data, quant(gate_mode(cur_k / N), cur_acc, bmem[cur_k]));
            check("out_gate", out_gate, cur_k / N);
            check("out_unit", out_unit, cur_k % N);
        end
        if (e_ready && acc_valid) begin
            check("bias_rd_addr", bias_rd_addr, elems);
            pending = 1;
            hs_cyc  = c;
            cur_k   = elems;
            cur_acc = acc_data;
        end
        if (bp_mode && elems == 5 && e_valid && bp_cnt < 10) bp_cnt++;
        if (e_valid && out_ready) begin
            pending  = 0;
            cons_cyc = c;
            elems++;
            n_res++;
        end
        if (!active && start) begin
            active    = 1;
            elems     = 0;
            cons_cyc  = c;
            start_cyc = c;
            n_starts++;
        end
        if (e_done) begin
            active   = 0;
            done_cyc = c;
        end
        c++;
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #1;
        sample();
    endtask

    task automatic run_to_idle(input int budget);
        int n = 0;
        step();
        while (active && n < budget) begin
            step();
            n++;
        end
        check("run_timeout", active, 0);
    endtask

    task automatic check_all_zero();
        check("rst_ctl", {busy, done, acc_ready, bias_rd_en, out_valid, comb_ctrl,
                          bias_rd_addr, out_gate, out_unit}, '0);
        check("rst_dat", {inpdt_R_reg, bias_buffer, out_data}, '0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NE; i++) bmem[i] = '0;

        // Reset values
        acc_valid = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_all_zero();
        rstn = 1;

        // Idle with acc_valid high and no start: nothing consumed
        p_acc = 100; p_rdy = 100; p_start = 0;
        repeat (100) step();

        // Full throughput, zero data and biases
        zero_data = 1;
        n_res = 0;
        kick = 1;
        run_to_idle(300);
        check("done_latency", done_cyc - start_cyc + 1, 16 * N + 2);
        check("thru_count", n_res, NE);

        // Randomized traffic with random biases and stray starts
        for (int i = 0; i < NE; i++) bmem[i] = 8'($urandom);
        zero_data = 0;
        p_acc = 70; p_rdy = 70; p_start = 3;
        repeat (1500) step();
        p_start = 0;
        n = 0;
        while (active && n < 2000) begin step(); n++; end
        check("drain_timeout", active, 0);

        // Backpressure on element 5
        p_acc = 100; p_rdy = 100;
        bp_mode = 1; bp_cnt = 0; n_res = 0;
        kick = 1;
        run_to_idle(400);
        check("bp_stall_len", bp_cnt, 10);
        check("bp_count", n_res, NE);
        bp_mode = 0;

        // Asynchronous reset while in QUANT
        p_acc = 80; p_rdy = 80;
        kick = 1;
        n = 0;
        step();
        while (!(pending && elems == 6 && (c - 1) == hs_cyc + 2) && n < 400) begin
            step();
            n++;
        end
        check("quant_reach", n < 400, 1);
        #1 rstn = 0;
        #1;
        check_all_zero();
        active = 0; pending = 0; elems = 0;
        n_aborts++;
        step();
        rstn = 1;
        n_res = 0;
        kick = 1;
        run_to_idle(600);
        check("post_rst_count", n_res, NE);

        repeat (5) step();
        check("done_per_start", n_dones, n_starts - n_aborts);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
